tristate_bus_arbiter: RTL

Control stage directly upstream of the per-requester tristate buffer stages on a shared bus. It arbitrates N requesters round-robin and produces a registered one-hot enable per buffer plus that buffer's registered data. It enforces bounded bursts and a mandatory all-released turnaround between owners, so two buffers never drive the bus in the same cycle.

---
 rtl/tristate_bus_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 26 ++
 rtl/tristate_bus_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/tristate_bus_pkg.sv
// tristate_bus_pkg: FSM state type and counter widths shared by tristate_bus_arbiter.
// Widths are sized for the largest legal BURST_MAX and TURN.
package tristate_bus_pkg;
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_TURN} state_e;
    localparam int BURST_LIMIT = 255;
    localparam int TURN_LIMIT  = 7;
    localparam int CNT_W  = $clog2(BURST_LIMIT + 1);
    localparam int TCNT_W = $clog2(TURN_LIMIT + 1);
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first asserted request at or above ptr_i, wrapping.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o
);
    localparam int IW = $clog2(N);
    logic [IW-1:0] j;
    logic          found;
    always_comb begin
        idx_o = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr_i) + k) % N);
            if (!found && req_i[j]) begin
                found = 1'b1;
                idx_o = j;
            end
        end
        gnt_o = found ? N'(1) << idx_o : '0;
    end
endmodule

// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: round-robin owner control for tristate buffers with registered enables/data and enforced turnaround.
// Define TRISTATE_PARK_EN to leave the last owner parked on the bus while idle.
module tristate_bus_arbiter
    import tristate_bus_pkg::*;
#(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int BURST_MAX = 4,
    parameter int TURN      = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] din,
    output logic [N-1:0]   drv_en,
    output logic [N*W-1:0] drv_data,
    output logic [N-1:0]   ack,
    output logic           busy
);
    localparam int IW = $clog2(N);
`ifdef TRISTATE_PARK_EN
    localparam bit PARK = 1'b1;
`else
    localparam bit PARK = 1'b0;
`endif
    state_e            state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d, ptr_q, ptr_d, win_idx;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [N-1:0]      en_q, en_d, ack_q, ack_d, win_gnt;
    logic [N*W-1:0]    data_q, data_d;
    logic              busy_q;

    rr_arbiter #(.N(N)) u_rr (.req_i(req), .ptr_i(ptr_q), .gnt_o(win_gnt), .idx_o(win_idx));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        en_d    = en_q;
        data_d  = data_q;
        ack_d   = '0;
        case (state_q)
            S_IDLE: if (|req) begin
                owner_d = win_idx;
                // Only a parked owner reclaiming its own bus may skip the turnaround
                if (!PARK || en_q == '0 || win_idx == owner_q) state_d = S_DRIVE;
                else begin
                    state_d = S_TURN;
                    tcnt_d  = TCNT_W'(TURN - 1);
                    en_d    = '0;
                end
            end
            S_DRIVE: if (req[owner_q] && cnt_q < CNT_W'(BURST_MAX)) begin
                data_d[owner_q*W +: W] = din[owner_q*W +: W];
                en_d  = N'(1) << owner_q;
                ack_d = en_d;
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d   = '0;
                ptr_d   = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
                state_d = |req ? S_TURN : S_IDLE;
                tcnt_d  = TCNT_W'(TURN - 1);
                en_d    = (PARK && !(|req)) ? en_q : '0;
            end
            S_TURN: if (tcnt_q != '0) tcnt_d = tcnt_q - 1'b1;
            else if (|req) begin
                // The last quiet edge already carries the new owner's first beat
                state_d = S_DRIVE;
                owner_d = win_idx;
                data_d[win_idx*W +: W] = din[win_idx*W +: W];
                en_d    = win_gnt;
                ack_d   = win_gnt;
                cnt_d   = CNT_W'(1);
            end else state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            en_q    <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            en_q    <= en_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            busy_q  <= state_d != S_IDLE;
        end
    end

    assign drv_en   = en_q;
    assign drv_data = data_q;
    assign ack      = ack_q;
    assign busy     = busy_q;
endmodule
